pc_sequencer: RTL

- Control FSM that owns the program-memory read address for the serial playback path.
- Sequences a one-shot header region (addresses 0..LOOP_START-1), then loops the body (LOOP_START..DEPTH-1) indefinitely.
- Address advances once per completed serial byte.
- Adds start/stop control, a handshaked jump into the body, and read strobes to the program memory.

---
 rtl/pc_seq_pkg.sv | 11 +
 rtl/pc_addr_counter.sv | 41 ++++
 rtl/pc_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and body-range check for pc_sequencer.
package pc_seq_pkg;

   typedef enum logic [1:0] {IDLE, HEADER, RUN} state_e;

   function automatic logic in_body(input logic [31:0] addr, input int unsigned lo,
                                    input int unsigned depth);
      return (addr >= lo) && (addr < depth);
   endfunction

endpackage

// File: rtl/pc_addr_counter.sv
// pc_addr_counter: loadable program address counter with body wrap and jump-target mux.
module pc_addr_counter #(
   parameter int ADDR_W     = 16,
   parameter int DEPTH      = 41065,
   parameter int LOOP_START = 93
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              inc,
   input  logic              load,
   input  logic              jump_ok,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [ADDR_W-1:0] addr,
   output logic              at_last,
   output logic              at_hdr_end
);

   localparam logic [ADDR_W-1:0] LS   = ADDR_W'(LOOP_START);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   logic [ADDR_W-1:0] addr_q, addr_d;

   assign at_last    = addr_q == LAST;
   assign at_hdr_end = addr_q == LS - ADDR_W'(1);
   assign addr       = addr_q;

   // Bad jump targets fall back to the body start.
   always_comb begin
      addr_d = clear ? '0
             : load  ? (jump_ok ? jump_addr : LS)
             : inc   ? (at_last ? LS : addr_q + ADDR_W'(1))
             : addr_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) addr_q <= '0;
      else          addr_q <= addr_d;
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-memory address FSM (one-shot header, looping body, handshaked jumps).
// Optional PC_LOOP_COUNT_EN adds a loop counter that ends playback after loop_limit passes.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DEPTH      = 41065,
   parameter int LOOP_START = 93,
   parameter int LOOP_W     = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              byte_stb,
   input  logic              start,
   input  logic              stop,
   input  logic              jump_req,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic              jump_ack,
   output logic              jump_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              hdr_done,
   output logic              wrap_pulse,
   output logic              busy
`ifdef PC_LOOP_COUNT_EN
   ,
   input  logic [LOOP_W-1:0] loop_limit,
   output logic [LOOP_W-1:0] loop_cnt,
   output logic              done
`endif
);

   localparam longint ADDR_SPAN = 64'd1 << ADDR_W;

   if (DEPTH > ADDR_SPAN || LOOP_START <= 0 || LOOP_START >= DEPTH || LOOP_W < 1) begin : g_bad_cfg
      $error("pc_sequencer: illegal DEPTH/LOOP_START/ADDR_W/LOOP_W combination");
   end

   state_e state_q, state_d;
   logic   mem_rd_q, mem_rd_d;
   logic   ack_q, ack_d;
   logic   err_q, err_d;
   logic   wrap_q, wrap_d;
   logic   clear, inc, load, jump_ok, at_last, at_hdr_end, last_loop, start_ok;

   assign jump_ok  = in_body(32'(jump_addr), LOOP_START, DEPTH);
   assign start_ok = state_q == IDLE && start && !stop;

   pc_addr_counter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LOOP_START(LOOP_START)) u_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (clear),
      .inc        (inc),
      .load       (load),
      .jump_ok    (jump_ok),
      .jump_addr  (jump_addr),
      .addr       (mem_addr),
      .at_last    (at_last),
      .at_hdr_end (at_hdr_end)
   );

   always_comb begin
      state_d  = state_q;
      clear    = 1'b0;
      inc      = 1'b0;
      load     = 1'b0;
      mem_rd_d = 1'b0;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      wrap_d   = 1'b0;
      if (stop) begin
         state_d = IDLE;
         clear   = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               clear    = 1'b1;
               state_d  = start ? HEADER : IDLE;
               mem_rd_d = start;
            end
            HEADER: if (byte_stb) begin
               inc      = 1'b1;
               mem_rd_d = 1'b1;
               state_d  = at_hdr_end ? RUN : HEADER;
            end
            RUN: if (byte_stb) begin
               mem_rd_d = 1'b1;
               if (jump_req) begin
                  load  = 1'b1;
                  ack_d = 1'b1;
                  err_d = !jump_ok;
               end else if (at_last && last_loop) begin
                  // Final pass complete: end playback instead of wrapping.
                  state_d  = IDLE;
                  clear    = 1'b1;
                  mem_rd_d = 1'b0;
               end else begin
                  inc    = 1'b1;
                  wrap_d = at_last;
               end
            end
            default: begin
               state_d = IDLE;
               clear   = 1'b1;
            end
         endcase
      end
   end

`ifdef PC_LOOP_COUNT_EN
   logic [LOOP_W-1:0] loop_cnt_q, loop_cnt_d;
   logic              done_q, done_d;

   assign last_loop = loop_limit != '0 && loop_cnt_q + LOOP_W'(1) == loop_limit;

   always_comb begin
      done_d     = state_q == RUN && !stop && byte_stb && !jump_req && at_last && last_loop;
      loop_cnt_d = start_ok ? '0 : (wrap_d || done_d) ? loop_cnt_q + LOOP_W'(1) : loop_cnt_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         loop_cnt_q <= '0;
         done_q     <= 1'b0;
      end else begin
         loop_cnt_q <= loop_cnt_d;
         done_q     <= done_d;
      end
   end

   assign loop_cnt = loop_cnt_q;
   assign done     = done_q;
`else
   assign last_loop = 1'b0;
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         mem_rd_q <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mem_rd_q <= mem_rd_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         wrap_q   <= wrap_d;
      end
   end

   assign mem_rd     = mem_rd_q;
   assign jump_ack   = ack_q;
   assign jump_err   = err_q;
   assign wrap_pulse = wrap_q;
   assign hdr_done   = state_q == RUN;
   assign busy       = state_q != IDLE;

endmodule
